jk_counter_rst: RTL

- Synchronous up/down binary counter built from a chain of JK flip-flop stages. Each stage is driven in JK encoding: hold, set, clear or toggle.
- Sits directly downstream of the library's JK latch cells. It is the first consumer that composes them into a clocked, multi-bit register with load and terminal-count.
- Intended as the library's reference sequential counter. Dividers and timers instantiate it.

---
 rtl/jk_pkg.sv | 22 ++
 rtl/jk_ff_rst.sv | 27 ++
 rtl/jk_counter_rst.sv | 51 +++++
 3 files changed

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK stage mode encoding and next-state helper
package jk_pkg;

    typedef logic [1:0] jk_mode_t;  // {J,K}

    localparam jk_mode_t JK_HOLD   = 2'b00;
    localparam jk_mode_t JK_CLEAR  = 2'b01;
    localparam jk_mode_t JK_SET    = 2'b10;
    localparam jk_mode_t JK_TOGGLE = 2'b11;

    function automatic logic jk_next(input jk_mode_t mode, input logic q);
        logic nq;
        case (mode)
            JK_CLEAR:  nq = 1'b0;
            JK_SET:    nq = 1'b1;
            JK_TOGGLE: nq = ~q;
            default:   nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_ff_rst.sv
// rtl/jk_ff_rst.sv - edge-triggered JK flip-flop stage with async active-low reset
module jk_ff_rst
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic out1,
    output logic out2
);

    logic q_r;

    // Master-slave pair collapses to one edge-sampled register; J/K only matter at the rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r <= 1'b0;
        end else begin
            q_r <= jk_next({j, k}, q_r);
        end
    end

    assign out1 = q_r;
    assign out2 = ~q_r;

endmodule

// File: rtl/jk_counter_rst.sv
// rtl/jk_counter_rst.sv - up/down loadable counter built from a chain of JK stages
module jk_counter_rst
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic     tog;
        jk_mode_t mode;

        // A stage flips when every lower bit is at its carry (up) or borrow (down) value.
        if (i == 0) begin : g_lsb
            assign tog = 1'b1;
        end else begin : g_upper
            assign tog = up ? (&q[i-1:0]) : ~(|q[i-1:0]);
        end

        always_comb begin
            mode = JK_HOLD;
            if (load) begin
                mode = {d[i], ~d[i]};
            end else if (en && tog) begin
                mode = JK_TOGGLE;
            end
        end

        jk_ff_rst u_ff (
            .clk  (clk),
            .reset(reset),
            .j    (mode[1]),
            .k    (mode[0]),
            .out1 (q[i]),
            .out2 (qn[i])
        );
    end

    // Not gated by load: downstream dividers see terminal count even on a reload edge.
    assign tc = en & (up ? (&q) : ~(|q));

endmodule
